prog_timer: RTL



---
 rtl/prog_timer.sv | 110 +++++++++++
 1 files changed

// File: rtl/prog_timer.sv
// Purpose: programmable restartable tick generator (period x prescale, periodic or one-shot, square out).
// Latency: all outputs registered; first tick is visible (P+1)*(S+1) edges after the start edge.
// Backpressure: none; tick is a single-cycle pulse and is not held for a consumer.
module prog_timer #(
  parameter int CTR_LEN = 26,
  parameter int PRE_LEN = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [CTR_LEN-1:0] period,
  input  logic [PRE_LEN-1:0] prescale,
  output logic               tick,
  output logic               running,
  output logic [CTR_LEN-1:0] count,
  output logic               square
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CTR_LEN-1:0] cnt_q, cnt_d;
  logic [PRE_LEN-1:0] pre_q, pre_d;
  logic [CTR_LEN-1:0] per_q, per_d;
  logic [PRE_LEN-1:0] scl_q, scl_d;
  logic               one_q, one_d;
  logic               tick_q, tick_d;
  logic               sq_q, sq_d;

  // Next-state and next-output logic; priority is stop > start > terminal-count handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    per_d   = per_q;
    scl_d   = scl_q;
    one_d   = one_q;
    tick_d  = 1'b0;
    sq_d    = sq_q;

    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      pre_d   = '0;
    end else if (start) begin
      // A start in RUN is a restart; any terminal count on this edge is dropped.
      state_d = RUN;
      per_d   = period;
      scl_d   = prescale;
      one_d   = mode;
      cnt_d   = '0;
      pre_d   = '0;
      sq_d    = 1'b0;
    end else if (state_q == RUN) begin
      if (pre_q == scl_q) begin
        pre_d = '0;
        // Compare before increment so the counter never exceeds the latched period.
        if (cnt_q == per_q) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          sq_d   = ~sq_q;
          if (one_q) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
      pre_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      per_q   <= '0;
      scl_q   <= '0;
      one_q   <= 1'b0;
      tick_q  <= 1'b0;
      sq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      per_q   <= per_d;
      scl_q   <= scl_d;
      one_q   <= one_d;
      tick_q  <= tick_d;
      sq_q    <= sq_d;
    end
  end

  assign tick    = tick_q;
  assign running = (state_q == RUN);
  assign count   = cnt_q;
  assign square  = sq_q;

endmodule
